// File: rtl/fp_sqrt_arb_pkg.sv
// Shared types and constants for the square-root arbiter.
// Bypass encodings follow IEEE-754 single precision.
package fp_sqrt_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
   localparam int          SIGN_BIT = 31;

   // sqrt(-0) is -0; every other negative operand has no real root.
   function automatic logic [31:0] bypass_result(input logic [31:0] op);
      return (op == NEG_ZERO) ? NEG_ZERO : QNAN;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr_i, wrapping; combinational, no backpressure.
// Grant is one-hot with a matching encoded index; all zero when nothing requests.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] idx_o
);

   localparam int IW = $clog2(N_REQ);

   logic [IW:0]   sum;
   logic [IW-1:0] j;
   logic          found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      sum   = '0;
      j     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr_i} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
         j = sum[IW-1:0];
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = j;
         end
      end
   end

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// Shares one iterative sqrt core among N_REQ requesters; one op in flight, negatives bypass the core.
// Bypass answers 1 cycle after accept, core path 2+L; requests stall (req_ready=0) until the response is taken.
module fp_sqrt_arbiter
   import fp_sqrt_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     resp_valid,
   output logic [31:0]          resp_data,
   output logic                 resp_err,
   input  logic [N_REQ-1:0]     resp_ready,
   output logic                 core_start,
   output logic [31:0]          core_in,
   input  logic                 core_done,
   input  logic [31:0]          core_result,
   output logic                 core_abort
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);

   state_t            state_q;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d, owner_q;
   logic [CW-1:0]     cnt_q;
   logic [N_REQ-1:0]  resp_valid_q, owner_oh;
   logic [31:0]       resp_data_q, core_in_q, sel_op;
   logic              resp_err_q, core_start_q, core_abort_q;
   logic [N_REQ-1:0]  gnt;
   logic [IW-1:0]     gnt_idx;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   always_comb begin
      sel_op = '0;
      for (int k = 0; k < N_REQ; k++)
         if (gnt[k]) sel_op = req_data[32*k +: 32];
   end

   assign owner_oh  = N_REQ'(1) << owner_q;
   assign rr_ptr_d  = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + IW'(1);
   assign req_ready = (rst_n && state_q == ST_IDLE) ? gnt : '0;

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign core_start = core_start_q;
   assign core_in    = core_in_q;
   assign core_abort = core_abort_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         cnt_q        <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         core_start_q <= 1'b0;
         core_in_q    <= '0;
         core_abort_q <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         core_abort_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (|req_valid) begin
               owner_q   <= gnt_idx;
               core_in_q <= sel_op;
               if (sel_op[SIGN_BIT]) begin
                  resp_data_q  <= bypass_result(sel_op);
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= gnt;
                  state_q      <= ST_RESP;
               end else begin
                  core_start_q <= 1'b1;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_q   <= '0;
               state_q <= ST_BUSY;
            end
            // A done arriving on the timeout cycle still wins over the abort.
            ST_BUSY: if (core_done) begin
               resp_data_q  <= core_result;
               resp_err_q   <= 1'b0;
               resp_valid_q <= owner_oh;
               state_q      <= ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               resp_data_q  <= QNAN;
               resp_err_q   <= 1'b1;
               core_abort_q <= 1'b1;
               resp_valid_q <= owner_oh;
               state_q      <= ST_RESP;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            ST_RESP: if (resp_ready[owner_q]) begin
               resp_valid_q <= '0;
               rr_ptr_q     <= rr_ptr_d;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Directed bench for fp_sqrt_arbiter with a fixed-latency sqrt core model.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_fp_sqrt_arbiter;

   localparam int N  = 4;
   localparam int TO = 64;
   localparam int L  = 47;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [32*N-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [31:0]     resp_data;
   logic            resp_err;
   logic [N-1:0]    resp_ready;
   logic            core_start;
   logic [31:0]     core_in;
   logic            core_done   = 1'b0;
   logic [31:0]     core_result = '0;
   logic            core_abort;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_sqrt_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_err    (resp_err),
      .resp_ready  (resp_ready),
      .core_start  (core_start),
      .core_in     (core_in),
      .core_done   (core_done),
      .core_result (core_result),
      .core_abort  (core_abort)
   );

   // Core model: done pulses L cycles after the start cycle; not tied to rst_n.
   logic        mdl_busy  = 1'b0;
   logic        mdl_never = 1'b0;
   int          mdl_cnt   = 0;
   logic [31:0] mdl_op    = '0;

   function automatic logic [31:0] sqrt_ref(input logic [31:0] op);
      case (op)
         32'h4080_0000: return 32'h4000_0000;
         32'h4110_0000: return 32'h4040_0000;
         32'h4180_0000: return 32'h4080_0000;
         32'h3F80_0000: return 32'h3F80_0000;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (mdl_busy) begin
         if (mdl_cnt == 1) begin
            core_done   <= 1'b1;
            core_result <= sqrt_ref(mdl_op);
            mdl_busy    <= 1'b0;
         end
         mdl_cnt <= mdl_cnt - 1;
      end else if (core_start && !mdl_never) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= L - 1;
         mdl_op   <= core_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input int idx, input logic [31:0] op, input logic [N-1:0] exp_gnt);
      req_data[32*idx +: 32] = op;
      req_valid[idx] = 1'b1;
      #1;
      chk("req_ready_grant", 32'(req_ready), 32'(exp_gnt));
   endtask

   task automatic run_until_resp(input int max_cyc, output int lat, output int n_start,
                                 output int n_abort, output logic [31:0] start_in);
      lat = -1; n_start = 0; n_abort = 0; start_in = '0;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = '0;
            start_in  = core_in;
         end
         n_start += int'(core_start);
         n_abort += int'(core_abort);
         if (resp_valid != '0) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic ack(input int idx);
      resp_ready[idx] = 1'b1;
      @(negedge clk);
      chk("resp_valid_clear", 32'(resp_valid), 32'h0);
      resp_ready = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      chk({tag, "_resp_data"},  resp_data,       32'h0);
      chk({tag, "_resp_err"},   32'(resp_err),   32'h0);
      chk({tag, "_core_start"}, 32'(core_start), 32'h0);
      chk({tag, "_core_in"},    core_in,         32'h0);
      chk({tag, "_core_abort"}, 32'(core_abort), 32'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          lat, ns, na, nr;
      logic [31:0] sin;
      logic [3:0]  gq[$];
      logic [3:0]  rvq[$];
      logic [31:0] rdq[$];
      logic [31:0] exp_rd [5];
      logic [31:0] got;

      rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single core request: 4.0 -> 2.0
      send(0, 32'h4080_0000, 4'b0001);
      run_until_resp(100, lat, ns, na, sin);
      chk("single_start_cnt", 32'(ns), 32'd1);
      chk("single_core_in", sin, 32'h4080_0000);
      chk("single_latency", 32'(lat), 32'd49);
      chk("single_resp_valid", 32'(resp_valid), 32'h1);
      chk("single_resp_data", resp_data, 32'h4000_0000);
      chk("single_resp_err", 32'(resp_err), 32'h0);
      chk("single_abort_cnt", 32'(na), 32'd0);
      ack(0);

      // Negative bypass (rr_ptr now 1; only requester 2 asks)
      send(2, 32'hC080_0000, 4'b0100);
      run_until_resp(10, lat, ns, na, sin);
      chk("neg_latency", 32'(lat), 32'd1);
      chk("neg_start_cnt", 32'(ns), 32'd0);
      chk("neg_resp_valid", 32'(resp_valid), 32'h4);
      chk("neg_resp_data", resp_data, 32'h7FC0_0000);
      chk("neg_resp_err", 32'(resp_err), 32'h0);
      ack(2);
      send(2, 32'h8000_0000, 4'b0100);
      run_until_resp(10, lat, ns, na, sin);
      chk("negzero_latency", 32'(lat), 32'd1);
      chk("negzero_start_cnt", 32'(ns), 32'd0);
      chk("negzero_resp_data", resp_data, 32'h8000_0000);
      ack(2);

      // Backpressure on requester 1 (rr_ptr now 3): 9.0 -> 3.0
      send(1, 32'h4110_0000, 4'b0010);
      run_until_resp(100, lat, ns, na, sin);
      chk("bp_latency", 32'(lat), 32'd49);
      req_data   = {32'h3F80_0000, 32'h4110_0000, 32'h4180_0000, 32'h4080_0000};
      req_valid  = 4'hF;
      resp_ready = 4'b1101;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("bp_req_ready", 32'(req_ready), 32'h0);
         chk("bp_resp_valid", 32'(resp_valid), 32'h2);
         chk("bp_resp_data", resp_data, 32'h4040_0000);
         @(negedge clk);
      end
      req_valid = '0; resp_ready = '0;
      ack(1);

      // Reset while BUSY (rr_ptr now 2)
      send(2, 32'h4080_0000, 4'b0100);
      run_until_resp(10, lat, ns, na, sin);
      chk("rstbusy_no_early_resp", 32'(lat), 32'hFFFF_FFFF);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rstbusy");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nr = 0; ns = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         nr += int'(resp_valid != '0);
         ns += int'(core_start);
      end
      chk("rstbusy_late_resp", 32'(nr), 32'd0);
      chk("rstbusy_late_start", 32'(ns), 32'd0);

      // Fairness from rr_ptr 0: all requesters valid, resp_ready tied high
      req_data   = {32'h8000_0000, 32'h4180_0000, 32'hBF80_0000, 32'h4080_0000};
      exp_rd     = '{32'h4000_0000, 32'h7FC0_0000, 32'h4080_0000, 32'h8000_0000, 32'h4000_0000};
      req_valid  = 4'hF;
      resp_ready = 4'hF;
      for (int c = 0; c < 600 && rdq.size() < 5; c++) begin
         #1;
         if (req_ready != '0 && gq.size() < 5) gq.push_back(req_ready);
         if (resp_valid != '0) begin
            rvq.push_back(resp_valid);
            rdq.push_back(resp_data);
         end
         @(negedge clk);
         if (gq.size() >= 5) req_valid = '0;
      end
      req_valid = '0; resp_ready = '0;
      for (int k = 0; k < 5; k++) begin
         got = (k < gq.size()) ? 32'(gq[k]) : 32'hDEAD_BEEF;
         chk($sformatf("fair_grant%0d", k), got, 32'(4'b0001 << (k % 4)));
         got = (k < rvq.size()) ? 32'(rvq[k]) : 32'hDEAD_BEEF;
         chk($sformatf("fair_resp_valid%0d", k), got, 32'(4'b0001 << (k % 4)));
         got = (k < rdq.size()) ? rdq[k] : 32'hDEAD_BEEF;
         chk($sformatf("fair_resp_data%0d", k), got, exp_rd[k]);
      end

      // Watchdog: core never completes (rr_ptr now 1)
      mdl_never = 1'b1;
      send(3, 32'h3F80_0000, 4'b1000);
      run_until_resp(200, lat, ns, na, sin);
      chk("wd_latency", 32'(lat), 32'd66);
      chk("wd_abort_cnt", 32'(na), 32'd1);
      chk("wd_resp_valid", 32'(resp_valid), 32'h8);
      chk("wd_resp_data", resp_data, 32'h7FC0_0000);
      chk("wd_resp_err", 32'(resp_err), 32'h1);
      @(negedge clk);
      chk("wd_abort_one_pulse", 32'(core_abort), 32'h0);
      chk("wd_resp_held", 32'(resp_valid), 32'h8);
      ack(3);
      mdl_never = 1'b0;

      // Normal request after the abort: 16.0 -> 4.0
      send(0, 32'h4180_0000, 4'b0001);
      run_until_resp(100, lat, ns, na, sin);
      chk("post_wd_latency", 32'(lat), 32'd49);
      chk("post_wd_resp_data", resp_data, 32'h4080_0000);
      chk("post_wd_resp_err", 32'(resp_err), 32'h0);
      chk("post_wd_abort_cnt", 32'(na), 32'd0);
      ack(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_sqrt_arbiter.md
# fp_sqrt_arbiter

Shares one iterative floating-point square-root core among N_REQ requesters. Round-robin selection, one operation in flight, per-requester valid/ready handshake on both request and response. Negative operands are short-circuited without occupying the core. A watchdog recovers from a core that never signals completion. Sits between requesting units and the square-root datapath/controller pair, which remains unchanged.

## Interface
- N_REQ, 4: number of requesters (2..8).
- TIMEOUT, 64: BUSY cycles without core_done before abort; must exceed the core's start-to-done latency (47).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i has an operand.
- req_data  in  32*N_REQ  IEEE-754 single operands; requester i at [32i+31:32i].
- req_ready  out  N_REQ  one-hot accept, combinational.
- resp_valid  out  N_REQ  one-hot result valid for the owning requester.
- resp_data  out  32  result, shared by all requesters.
- resp_err  out  1  qualifies resp_data; 1 = watchdog abort.
- resp_ready  in  N_REQ  requester i accepts its result.
- core_start  out  1  one-cycle start pulse to the core.
- core_in  out  32  operand to the core, stable from core_start until core_done.
- core_done  in  1  one-cycle completion pulse from the core.
- core_result  in  32  core result, valid with core_done.
- core_abort  out  1  one-cycle pulse on timeout; the top level ORs it into the core reset.

## Operation
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - The round-robin arbiter picks the first req_valid at or after rr_ptr, with wrap-around.
  - req_ready[g] = 1 for that cycle only; the handshake completes in the same cycle.
  - Latch operand and owner g.
  - If operand sign = 1: bypass result is 32'h8000_0000 when the operand is -0, otherwise quiet NaN 32'h7FC0_0000. resp_err = 0. Go to RESP.
  - Otherwise go to ISSUE. No req_valid: stay in IDLE.
- ISSUE: core_start = 1 for one cycle; clear the watchdog counter; go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - core_done = 1: latch core_result, resp_err = 0, go to RESP.
  - Counter reaches TIMEOUT-1 without core_done: resp_data = QNAN, resp_err = 1, core_abort = 1 for one cycle, go to RESP.
  - If core_done arrives in the same cycle as the timeout, the done wins and there is no abort.
- RESP:
  - resp_valid[owner] = 1; resp_data and resp_err are held stable.
  - On resp_ready[owner]: rr_ptr = (owner+1) mod N_REQ; go to IDLE.
  - resp_ready from non-owners is ignored.
- core_done outside BUSY is ignored.
- req_ready is 0 in every state except IDLE, so requests wait with no queueing.
- Reset values: state IDLE, rr_ptr 0, counter 0, all outputs 0 (req_ready 0, resp_valid 0, resp_data 0, resp_err 0, core_start 0, core_in 0, core_abort 0).
- Reset mid-operation drops the in-flight operation silently and produces no response.

## Timing
- Accept occurs in cycle T.
- Bypass path: resp_valid at T+1.
- Core path: core_start at T+1. If core_done comes at T+1+L, resp_valid is at T+2+L.
- Back-to-back: the earliest next accept is the cycle after the resp_ready handshake.
- Minimum period between bypass operations is 2 cycles.
- All outputs are registered except req_ready, which is combinational from req_valid, rr_ptr and state.
- Timeout: resp_valid appears TIMEOUT+1 cycles after core_start.

## Structure
- Package fp_sqrt_arb_pkg holds: the state enum (2 bits), QNAN = 32'h7FC0_0000, NEG_ZERO = 32'h8000_0000, and the sign-bit index 31.
- Sub-module rr_arbiter, parameterised by N_REQ:
  - Inputs: req vector, rr_ptr.
  - Output: one-hot grant plus encoded index.
  - Purely combinational.
- The top level holds the FSM, operand/result registers, owner register, rr_ptr and watchdog counter. The counter width is $clog2(TIMEOUT).

## Test plan
- Single request: req 0 with 32'h4080_0000 (4.0), core model L=47 → core_start at T+1, core_in = 32'h4080_0000; resp_valid[0] at T+49 with resp_data 32'h4000_0000, resp_err 0.
- Fairness: all four requesters hold valid continuously, resp_ready tied high → grants occur in order 0,1,2,3,0; no requester is granted twice before the others.
- Negative bypass: req 2 with 32'hC080_0000 → resp_data 32'h7FC0_0000 at T+1 and core_start never asserts. Then 32'h8000_0000 → resp_data 32'h8000_0000.
- Backpressure: hold resp_ready[1] low for 10 cycles → resp_valid[1] and resp_data stay stable; req_ready stays 0 for all requesters throughout.
- Watchdog: core model never pulses done, TIMEOUT=64 → core_abort pulses once; resp_valid with resp_err 1 and resp_data QNAN at core_start+65. A following request completes normally.
- Reset mid-BUSY: deassert rst_n during BUSY → all outputs 0 immediately and rr_ptr 0. A late core_done after reset produces no response.
